timebase_ctrl: RTL and testbench

TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

---
 rtl/timebase_pkg.sv | 13 +
 rtl/tb_prescaler.sv | 40 ++++
 rtl/timebase_ctrl.sv | 98 +++++++++
 tb/tb_timebase_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timebase_pkg.sv
// Shared types and constants for the timebase controller and its prescaler.
package timebase_pkg;

  localparam int unsigned PERIOD_W           = 16;
  localparam int unsigned PKG_DEFAULT_PERIOD = 521;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tb_prescaler.sv
// Clock prescaler: counts 0..period-1 while running and flags the last count.
module tb_prescaler
  import timebase_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_cnt_next;
  logic                r_active;
  logic                r_tick;

  // run is the controller's next-cycle run state, so the tick flop lines up
  // with the count it describes.
  always_comb begin
    w_cnt_next = '0;
    if (run && r_active) begin
      w_cnt_next = (r_cnt == period - PERIOD_W'(1)) ? '0 : r_cnt + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_active <= run;
      r_tick   <= run && (w_cnt_next == period - PERIOD_W'(1));
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/timebase_ctrl.sv
// Timebase controller: config handshake, run FSM and tick counter around a
// prescaler that generates the enable pulses.
module timebase_ctrl
  import timebase_pkg::*;
#(
  parameter int unsigned DEFAULT_PERIOD = PKG_DEFAULT_PERIOD,
  parameter int unsigned Q_WIDTH        = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [Q_WIDTH-1:0]  cfg_count,
  input  logic                start,
  input  logic                stop,
  output logic                enable,
  output logic [Q_WIDTH-1:0]  q,
  output logic                busy,
  output logic                done
);

  state_e              r_state;
  state_e              w_state_next;
  logic [PERIOD_W-1:0] r_period;
  logic [Q_WIDTH-1:0]  r_count;
  logic [Q_WIDTH-1:0]  r_q;
  logic                r_done;
  logic                w_tick;
  logic                w_cfg_xfer;
  logic                w_last_tick;
  logic                w_run_next;

  assign w_cfg_xfer  = cfg_valid && (r_state == IDLE);
  assign w_last_tick = w_tick && (r_count != '0) && (r_q + Q_WIDTH'(1) == r_count);
  assign w_run_next  = (w_state_next == RUN);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (!w_cfg_xfer && start) w_state_next = RUN;
      end
      RUN: begin
        if (stop)             w_state_next = IDLE;
        else if (w_last_tick) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (w_state_next == DONE);
    end
  end

  // A zero period is stored as 1 so the prescaler never sees an empty range.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= PERIOD_W'(DEFAULT_PERIOD);
      r_count  <= '0;
    end else if (w_cfg_xfer) begin
      r_period <= (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
      r_count  <= cfg_count;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (r_state == IDLE && w_state_next == RUN) begin
      r_q <= '0;
    end else if (r_state == RUN && w_tick && !stop) begin
      r_q <= r_q + Q_WIDTH'(1);
    end
  end

  tb_prescaler u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (w_run_next),
    .period  (r_period),
    .tick    (w_tick)
  );

  assign cfg_ready = (r_state == IDLE);
  assign busy      = (r_state == RUN);
  assign enable    = w_tick;
  assign done      = r_done;
  assign q         = r_q;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Bench for timebase_ctrl: cycle-level arithmetic model plus directed scenarios.
module tb_timebase_ctrl;

  localparam int QW = 8;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic          cfg_valid  = 1'b0;
  logic [15:0]   cfg_period = '0;
  logic [QW-1:0] cfg_count  = '0;
  logic          start      = 1'b0;
  logic          stop       = 1'b0;
  logic          cfg_ready;
  logic          enable;
  logic [QW-1:0] q;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  always #5 clk = ~clk;

  timebase_ctrl #(.DEFAULT_PERIOD(521), .Q_WIDTH(QW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
    .start      (start),
    .stop       (stop),
    .enable     (enable),
    .q          (q),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=running 2=finished; m_k = cycles elapsed in the run.
  // A tick falls on run cycle k whenever (k+1) is a multiple of the period.
  int m_mode = 0;
  int m_k    = 0;
  int m_P    = 521;
  int m_N    = 0;
  int m_q    = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= 0; m_k <= 0; m_P <= 521; m_N <= 0; m_q <= 0;
    end else begin
      case (m_mode)
        0: begin
          if (cfg_valid) begin
            m_P <= (cfg_period == 16'd0) ? 1 : int'(cfg_period);
            m_N <= int'(cfg_count);
          end else if (start) begin
            m_mode <= 1; m_k <= 0; m_q <= 0;
          end
        end
        1: begin
          if (stop) begin
            m_mode <= 0;
          end else begin
            if (((m_k + 1) % m_P) == 0) begin
              m_q <= (m_q + 1) % 256;
              if (m_N != 0 && ((m_q + 1) % 256) == m_N) m_mode <= 2;
            end
            m_k <= m_k + 1;
          end
        end
        default: m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("enable",    32'(enable),    (m_mode == 1 && ((m_k + 1) % m_P) == 0) ? 32'd1 : 32'd0);
      chk("q",         32'(q),         32'(m_q));
      chk("busy",      32'(busy),      (m_mode == 1) ? 32'd1 : 32'd0);
      chk("done",      32'(done),      (m_mode == 2) ? 32'd1 : 32'd0);
      chk("cfg_ready", 32'(cfg_ready), (m_mode == 0) ? 32'd1 : 32'd0);
    end
  end

  // All tasks are entered just after a falling edge and return at one.
  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic configure(input logic [15:0] p, input logic [QW-1:0] c);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_count  = c;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    int first_en, last_en, n_en, done_seen;
    logic [31:0] en_mask, done_mask;

    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // Default period after reset
    start_pulse();
    first_en = 0; last_en = 0; n_en = 0;
    for (int n = 1; n <= 1564; n++) begin
      if (n > 1) @(negedge clk);
      if (enable) begin
        n_en++;
        if (n_en == 1) first_en = n;
        last_en = n;
      end
      if (n == 522) chk("dflt_q1", 32'(q), 32'd1);
      if (n == 1564) chk("dflt_q3", 32'(q), 32'd3);
    end
    chk("dflt_first", 32'(first_en), 32'd521);
    chk("dflt_last", 32'(last_en), 32'd1563);
    chk("dflt_ticks", 32'(n_en), 32'd3);
    stop_pulse();
    chk("dflt_stop_idle", 32'(cfg_ready), 32'd1);
    chk("dflt_stop_q", 32'(q), 32'd3);

    // Counted run: period 4, three ticks
    configure(16'd4, 8'd3);
    start_pulse();
    en_mask = '0; done_mask = '0;
    for (int n = 1; n <= 14; n++) begin
      if (n > 1) @(negedge clk);
      if (enable) en_mask[n] = 1'b1;
      if (done) done_mask[n] = 1'b1;
      if (n == 14) begin
        chk("cnt_q_held", 32'(q), 32'd3);
        chk("cnt_ready", 32'(cfg_ready), 32'd1);
      end
    end
    chk("cnt_en_mask", en_mask, 32'h0000_1110);
    chk("cnt_done_mask", done_mask, 32'h0000_2000);

    // Zero period means a tick every cycle; q wraps after 256
    configure(16'd0, 8'd0);
    start_pulse();
    n_en = 0;
    for (int n = 1; n <= 257; n++) begin
      if (n > 1) @(negedge clk);
      if (enable) n_en++;
      if (n == 256) chk("wrap_q255", 32'(q), 32'd255);
      if (n == 257) begin
        chk("wrap_q0", 32'(q), 32'd0);
        chk("wrap_busy", 32'(busy), 32'd1);
      end
    end
    chk("wrap_ticks", 32'(n_en), 32'd257);
    stop_pulse();

    // Stop on the final tick cycle
    configure(16'd2, 8'd2);
    start_pulse();
    repeat (3) @(negedge clk);
    chk("stop_en", 32'(enable), 32'd1);
    stop_pulse();
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_q", 32'(q), 32'd1);
    chk("stop_ready", 32'(cfg_ready), 32'd1);
    done_seen = 0;
    for (int n = 0; n < 4; n++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    chk("stop_no_done", 32'(done_seen), 32'd0);

    // Config together with start: config wins, no run
    cfg_valid = 1'b1; cfg_period = 16'd3; cfg_count = 8'd1; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    chk("hs_norun", 32'(busy), 32'd0);
    start_pulse();
    en_mask = '0; done_mask = '0;
    for (int n = 1; n <= 5; n++) begin
      if (n > 1) @(negedge clk);
      if (enable) en_mask[n] = 1'b1;
      if (done) done_mask[n] = 1'b1;
    end
    chk("hs_en_mask", en_mask, 32'h0000_0008);
    chk("hs_done_mask", done_mask, 32'h0000_0010);

    // Config offered during a run is held off
    configure(16'd5, 8'd0);
    start_pulse();
    cfg_valid = 1'b1; cfg_period = 16'd2; cfg_count = 8'd7;
    en_mask = '0;
    for (int n = 1; n <= 11; n++) begin
      if (n > 1) @(negedge clk);
      if (enable) en_mask[n] = 1'b1;
      if (n == 2) chk("hs_run_ready", 32'(cfg_ready), 32'd0);
    end
    chk("hs_run_en_mask", en_mask, 32'h0000_0420);
    stop = 1'b1; cfg_valid = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    chk("hs_run_q", 32'(q), 32'd2);

    // Reset in the middle of a run, on a tick cycle
    start_pulse();
    repeat (9) @(negedge clk);
    chk("mrst_pre_en", 32'(enable), 32'd1);
    chk("mrst_pre_q", 32'(q), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_enable", 32'(enable), 32'd0);
    chk("mrst_q", 32'(q), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    start_pulse();
    first_en = 0; done_seen = 0;
    for (int n = 1; n <= 521; n++) begin
      if (n > 1) @(negedge clk);
      if (enable && first_en == 0) first_en = n;
      if (done) done_seen++;
    end
    chk("mrst_first", 32'(first_en), 32'd521);
    chk("mrst_no_done", 32'(done_seen), 32'd0);
    stop_pulse();

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
